// File: rtl/iter_div_unit_pkg.sv
// rtl/iter_div_unit_pkg.sv - shared state encoding and div-op encoding for the EXE-stage divider
package iter_div_unit_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Decode hands the unit {signed, rem}; the same zip is kept for the latched op.
   typedef enum logic [1:0] {
      DIV_OP_DIVU = 2'b00,
      DIV_OP_MODU = 2'b01,
      DIV_OP_DIV  = 2'b10,
      DIV_OP_MOD  = 2'b11
   } div_op_e;

   function automatic div_op_e div_op_zip(input logic is_signed, input logic is_rem);
      return div_op_e'({is_signed, is_rem});
   endfunction

   function automatic logic op_is_signed(input div_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/iter_div_unit_div_step.sv
// rtl/iter_div_unit_div_step.sv - one restoring radix-2 shift/trial-subtract step
module iter_div_unit_div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W:0]   rem,
   input  logic [DATA_W-1:0] quo,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W:0]   rem_next,
   output logic [DATA_W-1:0] quo_next
);

   logic [DATA_W+1:0] shifted;
   logic [DATA_W+1:0] diff;
   logic              neg;

   always_comb begin
      shifted  = {rem, quo[DATA_W-1]};
      diff     = {1'b0, shifted[DATA_W:0]} - {2'b00, divisor};
      // A set top bit means the shifted value already exceeds any divisor.
      neg      = diff[DATA_W+1] & ~shifted[DATA_W+1];
      rem_next = neg ? shifted[DATA_W:0] : diff[DATA_W:0];
      quo_next = {quo[DATA_W-2:0], ~neg};
   end

endmodule

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - multi-cycle signed/unsigned DIV/MOD unit with valid/ready and flush
module iter_div_unit
   import iter_div_unit_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int EARLY_ZERO = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_signed,
   input  logic              in_rem,
   input  logic [DATA_W-1:0] in_dividend,
   input  logic [DATA_W-1:0] in_divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   logic [1:0]        state;
   div_op_e           op_q;
   logic              dvd_neg_q;
   logic              dsr_neg_q;
   logic              dsr_zero_q;
   logic [DATA_W:0]   rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] dsr_q;
   logic [CNT_W-1:0]  count;

   logic              dvd_neg;
   logic              dsr_neg;
   logic              dsr_zero;
   logic [DATA_W-1:0] dvd_abs;
   logic [DATA_W-1:0] dsr_abs;
   logic [DATA_W:0]   step_rem;
   logic [DATA_W-1:0] step_quo;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;

   always_comb begin
      dvd_neg  = in_signed & in_dividend[DATA_W-1];
      dsr_neg  = in_signed & in_divisor[DATA_W-1];
      dsr_zero = (in_divisor == '0);
      dvd_abs  = dvd_neg ? (~in_dividend + 1'b1) : in_dividend;
      dsr_abs  = dsr_neg ? (~in_divisor + 1'b1) : in_divisor;
   end

   iter_div_unit_div_step #(
      .DATA_W (DATA_W)
   ) u_div_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dsr_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         op_q       <= DIV_OP_DIVU;
         dvd_neg_q  <= 1'b0;
         dsr_neg_q  <= 1'b0;
         dsr_zero_q <= 1'b0;
         rem_q      <= '0;
         quo_q      <= '0;
         dsr_q      <= '0;
         count      <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q       <= div_op_zip(in_signed, in_rem);
                  dvd_neg_q  <= dvd_neg;
                  dsr_neg_q  <= dsr_neg;
                  dsr_zero_q <= dsr_zero;
                  dsr_q      <= dsr_abs;
                  count      <= CNT_W'(DATA_W);
                  // Zero divisor shortcut: load what the full iteration would produce.
                  if ((EARLY_ZERO != 0) && dsr_zero) begin
                     rem_q <= {1'b0, dvd_abs};
                     quo_q <= '1;
                     state <= ST_DONE;
                  end else begin
                     rem_q <= '0;
                     quo_q <= dvd_abs;
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               count <= count - 1'b1;
               if (count == CNT_W'(1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Divide by zero keeps the all-ones quotient regardless of operand signs.
   always_comb begin
      quo_fix = (op_is_signed(op_q) && (dvd_neg_q ^ dsr_neg_q) && !dsr_zero_q)
                ? (~quo_q + 1'b1) : quo_q;
      rem_fix = dvd_neg_q ? (~rem_q[DATA_W-1:0] + 1'b1) : rem_q[DATA_W-1:0];
   end

   always_comb begin
      in_ready   = (state == ST_IDLE);
      busy       = (state != ST_IDLE);
      out_valid  = (state == ST_DONE);
      out_result = '0;
      if (state == ST_DONE) begin
         out_result = op_is_rem(op_q) ? rem_fix : quo_fix;
      end
   end

endmodule

// File: tb/tb_iter_div_unit.sv
// tb/tb_iter_div_unit.sv - directed self-checking bench for iter_div_unit (EARLY_ZERO 1 and 0)
module tb_iter_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_signed;
   logic        in_rem;
   logic [31:0] in_dividend;
   logic [31:0] in_divisor;
   logic        out_ready;

   logic        in_ready,  out_valid,  busy;
   logic [31:0] out_result;
   logic        in_ready_nz, out_valid_nz, busy_nz;
   logic [31:0] out_result_nz;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   iter_div_unit #(.DATA_W(32), .EARLY_ZERO(1)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_signed   (in_signed),
      .in_rem      (in_rem),
      .in_dividend (in_dividend),
      .in_divisor  (in_divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .busy        (busy)
   );

   iter_div_unit #(.DATA_W(32), .EARLY_ZERO(0)) dut_nz (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready_nz),
      .in_signed   (in_signed),
      .in_rem      (in_rem),
      .in_dividend (in_dividend),
      .in_divisor  (in_divisor),
      .out_valid   (out_valid_nz),
      .out_ready   (out_ready),
      .out_result  (out_result_nz),
      .busy        (busy_nz)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for both units idle, then present one request for exactly one edge.
   task automatic issue(input string tag, input logic s, input logic r,
                        input logic [31:0] a, input logic [31:0] b);
      int c;
      c = 0;
      while (!(in_ready && in_ready_nz) && c < 100) begin
         tick();
         c++;
      end
      check({tag, "_ready"}, 32'(in_ready && in_ready_nz), 32'd1);
      in_signed   = s;
      in_rem      = r;
      in_dividend = a;
      in_divisor  = b;
      in_valid    = 1'b1;
      tick();
      in_valid    = 1'b0;
      in_dividend = 32'hDEAD_BEEF;
      in_divisor  = 32'h0000_0003;
   endtask

   // Latency counts the accept cycle as 1; 0 means the result never appeared.
   task automatic wait_both(output logic [31:0] ra, output int la,
                            output logic [31:0] rb, output int lb);
      la = 0;
      lb = 0;
      ra = 'x;
      rb = 'x;
      for (int c = 1; c <= 100; c++) begin
         if (la == 0 && out_valid) begin
            la = c;
            ra = out_result;
         end
         if (lb == 0 && out_valid_nz) begin
            lb = c;
            rb = out_result_nz;
         end
         if (la != 0 && lb != 0) break;
         tick();
      end
   endtask

   task automatic run_op(input string tag, input logic s, input logic r,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int exp_lat_nz);
      logic [31:0] ra, rb;
      int la, lb;
      issue(tag, s, r, a, b);
      wait_both(ra, la, rb, lb);
      check({tag, "_res"}, ra, exp);
      check({tag, "_lat"}, 32'(la), 32'(exp_lat));
      check({tag, "_res_nz"}, rb, exp);
      check({tag, "_lat_nz"}, 32'(lb), 32'(exp_lat_nz));
      tick();
   endtask

   initial begin
      logic [31:0] ra, rb;
      int la, lb, seen;

      resetn      = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_signed   = 1'b0;
      in_rem      = 1'b0;
      in_dividend = '0;
      in_divisor  = '0;
      out_ready   = 1'b1;
      repeat (3) tick();

      check("rst_in_ready",   32'(in_ready),  32'd1);
      check("rst_busy",       32'(busy),      32'd0);
      check("rst_out_valid",  32'(out_valid), 32'd0);
      check("rst_out_result", out_result,     32'd0);
      resetn = 1'b1;
      tick();

      run_op("udiv_7_2",   1'b0, 1'b0, 32'd7, 32'd2, 32'h0000_0003, 33, 33);
      run_op("umod_7_2",   1'b0, 1'b1, 32'd7, 32'd2, 32'h0000_0001, 33, 33);
      run_op("sdiv_m7_2",  1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 33);
      run_op("smod_m7_2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 33);
      run_op("sdiv_7_m2",  1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 33);
      run_op("smod_7_m2",  1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33, 33);
      run_op("udiv_zero",  1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 33);
      run_op("umod_zero",  1'b0, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 33);
      run_op("sdiv_zero",  1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 33);
      run_op("smod_zero",  1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 33);
      run_op("sdiv_ovf",   1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 33);
      run_op("smod_ovf",   1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 33);
      run_op("udiv_max_1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 33);

      // Flush with in_valid while idle must not accept.
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush_idle_busy",  32'(busy),     32'd0);
      check("flush_idle_ready", 32'(in_ready), 32'd1);

      // Flush ten cycles into a calculation.
      issue("flush_calc", 1'b0, 1'b0, 32'd100, 32'd7);
      seen = 0;
      repeat (9) begin
         if (out_valid || out_valid_nz) seen++;
         tick();
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy",      32'(busy || busy_nz),           32'd0);
      check("flush_in_ready",  32'(in_ready && in_ready_nz),   32'd1);
      check("flush_out_valid", 32'(out_valid || out_valid_nz), 32'd0);
      repeat (40) begin
         if (out_valid || out_valid_nz) seen++;
         tick();
      end
      check("flush_no_result", 32'(seen), 32'd0);
      run_op("udiv_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33, 33);
      run_op("umod_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 33, 33);

      // Backpressure in DONE.
      out_ready = 1'b0;
      issue("bp", 1'b0, 1'b0, 32'd1000, 32'd10);
      wait_both(ra, la, rb, lb);
      check("bp_res", ra, 32'd100);
      check("bp_lat", 32'(la), 32'd33);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid",  32'(out_valid), 32'd1);
         check("bp_hold_result", out_result,     32'd100);
         check("bp_hold_ready",  32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready),  32'd1);

      // Reset in the middle of CALC.
      issue("rst_calc", 1'b1, 1'b0, 32'd50, 32'd5);
      repeat (5) tick();
      check("rst_calc_busy_pre", 32'(busy), 32'd1);
      resetn = 1'b0;
      tick();
      check("rst_calc_valid",  32'(out_valid),  32'd0);
      check("rst_calc_result", out_result,      32'd0);
      check("rst_calc_busy",   32'(busy),       32'd0);
      check("rst_calc_ready",  32'(in_ready),   32'd1);
      resetn = 1'b1;
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid || out_valid_nz) seen++;
      end
      check("rst_calc_no_result", 32'(seen), 32'd0);
      run_op("sdiv_after_rst", 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 33);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
